// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_if
//  Function : Byte handshake between the host-side bus logic and the UART
//             transmitter (valid/ready with an 8-bit payload).
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  // Host side offers bytes and watches for back-pressure.
  modport master (output tx_valid, output tx_data, input tx_ready);
  // Transmitter side accepts bytes and reports FIFO space.
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Function : UART transmitter with input FIFO. Serialises buffered bytes as
//             8N1 / 8N2 frames, LSB first, timed by a shared 16x tick enable.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tick,
  uart_tx_if.slave                         bus,
  output logic                             tx_pin,
  output logic                             tx_busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
  // One extra bit is needed only to count the 32 ticks of a double stop bit.
  localparam int c_TICK_W = (STOP_BITS == 2) ? 5 : 4;

  localparam logic [c_TICK_W-1:0] c_BIT_LAST  = c_TICK_W'(15);
  localparam logic [c_TICK_W-1:0] c_STOP_LAST = c_TICK_W'(16 * STOP_BITS - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and occupancy
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_full;

  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [7:0]          w_head;
  logic [c_CNT_W-1:0]  w_count_nxt;

  // Ready is taken from the registered full flag only, so a pop frees space
  // one cycle later rather than combinationally.
  assign w_push  = bus.tx_valid && !r_full;
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Payload storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.tx_data;
    end
  end

  // Pointers wrap naturally; full/empty come from the occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
    end
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_TICK_W-1:0] w_tick_nxt;
  logic [2:0]          r_bit_cnt;
  logic [2:0]          w_bit_nxt;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_nxt;
  logic                r_tx_pin;
  logic                w_pin_nxt;
  logic                r_tx_done;
  logic                w_done_nxt;

  // State, counters and the line flop; reset returns the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx_pin   <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_pin   <= w_pin_nxt;
      r_tx_done  <= w_done_nxt;
    end
  end

  // Next-state logic: each bit lasts 16 ticks; the line value is precomputed
  // so it changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_pin_nxt   = r_tx_pin;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        w_pin_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tick_nxt  = '0;
          w_pin_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end

      START: begin
        if (tick) begin
          if (r_tick_cnt == c_BIT_LAST) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_pin_nxt   = r_shift[0];
            w_state_nxt = DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (r_tick_cnt == c_BIT_LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              w_pin_nxt   = 1'b1;
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
              w_pin_nxt = r_shift[1];
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        w_pin_nxt = 1'b1;
        if (tick) begin
          if (r_tick_cnt == c_STOP_LAST) begin
            w_tick_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_pin_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.tx_ready = !r_full;
  assign tx_pin       = r_tx_pin;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done      = r_tx_done;
  assign fifo_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Function : Self-checking bench for uart_tx. A frame-level reference model
//             predicts line level, busy, done, occupancy and ready each cycle;
//             a mid-bit decoder rebuilds the bytes seen on the line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int FIFO_DEPTH     = 16;
  localparam int STOP_BITS      = 1;
  localparam int c_FRAME_TICKS  = 16 * (9 + STOP_BITS);
  localparam int c_CNT_W        = $clog2(FIFO_DEPTH + 1);

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               tick  = 1'b0;
  logic               tx_pin;
  logic               tx_busy;
  logic               tx_done;
  logic [c_CNT_W-1:0] fifo_count;

  uart_tx_if bus ();

  uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .bus        (bus),
    .tx_pin     (tx_pin),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Tick source: 0 = held low, 1 = every tick_div clocks, 2 = random sparse.
  int tick_mode  = 1;
  int tick_div   = 4;
  int tick_phase = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (tick_mode)
      0: tick = 1'b0;
      1: begin
        if (tick_phase >= tick_div - 1) begin
          tick       = 1'b1;
          tick_phase = 0;
        end else begin
          tick       = 1'b0;
          tick_phase = tick_phase + 1;
        end
      end
      default: tick = !tick && ($urandom_range(0, 2) == 0);
    endcase
  end

  // --------------------------------------------------------------------------
  // Reference model: a frame is a list of line levels indexed by tick count.
  // --------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] rx_q[$];
  bit         m_active   = 1'b0;
  int         m_ticks    = 0;
  logic [7:0] m_byte     = '0;
  bit         m_done_exp = 1'b0;
  bit         p_tick     = 1'b0;
  bit         p_push     = 1'b0;
  logic [7:0] p_data     = '0;
  logic [7:0] rx_shift   = '0;
  int         dut_done_cnt = 0;

  // Line level k/16 ticks into a frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int         k;
    logic [7:0] s;
    k = t / 16;
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      s = b >> (k - 1);
      return s[0];
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_q.delete();
      m_sent.delete();
      rx_q.delete();
      m_active   = 1'b0;
      m_ticks    = 0;
      m_done_exp = 1'b0;
      p_tick     = 1'b0;
      p_push     = 1'b0;
    end else begin
      // Effect of the rising edge just past.
      m_done_exp = 1'b0;
      if (m_active) begin
        if (p_tick) begin
          m_ticks = m_ticks + 1;
          if ((m_ticks % 16) == 8 && (m_ticks / 16) >= 1 && (m_ticks / 16) <= 8)
            rx_shift = {tx_pin, rx_shift[7:1]};
          if (m_ticks == c_FRAME_TICKS) begin
            m_active   = 1'b0;
            m_done_exp = 1'b1;
            rx_q.push_back(rx_shift);
          end
        end
      end else if (m_q.size() != 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_ticks  = 0;
      end
      if (p_push) begin
        m_q.push_back(p_data);
        m_sent.push_back(p_data);
      end

      check_val("tx_pin", 32'(tx_pin), 32'(m_active ? frame_bit(m_byte, m_ticks) : 1'b1));
      check_val("tx_busy", 32'(tx_busy), 32'(m_active));
      check_val("tx_done", 32'(tx_done), 32'(m_done_exp));
      check_val("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      check_val("tx_ready", 32'(bus.tx_ready), 32'(m_q.size() != FIFO_DEPTH));
      if (tx_done) dut_done_cnt = dut_done_cnt + 1;

      // Inputs that the next rising edge will consume.
      p_tick = tick;
      p_push = bus.tx_valid && (m_q.size() < FIFO_DEPTH);
      p_data = bus.tx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.tx_valid = v;
    bus.tx_data  = d;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!m_active && m_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check_val({tag, "_len"}, 32'(rx_q.size()), 32'(m_sent.size()));
    for (int i = 0; i < m_sent.size() && i < rx_q.size(); i++)
      check_val({tag, "_byte"}, 32'(rx_q[i]), 32'(m_sent[i]));
    rx_q.delete();
    m_sent.delete();
  endtask

  int base;

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    // Reset and idle with ticks running.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_pin", 32'(tx_pin), 32'd1);
    check_val("rst_ready", 32'(bus.tx_ready), 32'd1);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_busy", 32'(tx_busy), 32'd0);
    repeat (1000) @(posedge clk);
    check_val("idle_done_n", 32'(dut_done_cnt), 32'd0);

    // Single byte 0xA5, tick every 4 clk.
    base = dut_done_cnt;
    drive(1'b1, 8'hA5);
    drive(1'b0, 8'h00);
    wait_idle("a5", 3000);
    check_val("a5_done_n", 32'(dut_done_cnt - base), 32'd1);
    check_val("a5_rx", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'hA5);
    check_stream("a5");

    // Burst of three behind a frame already on the line.
    base = dut_done_cnt;
    drive(1'b1, 8'h81);
    drive(1'b0, 8'h00);
    repeat (4) @(posedge clk);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    @(negedge clk);
    check_val("burst_cnt1", 32'(fifo_count), 32'd1);
    drive(1'b1, 8'h55);
    @(negedge clk);
    check_val("burst_cnt2", 32'(fifo_count), 32'd2);
    drive(1'b0, 8'h00);
    @(negedge clk);
    check_val("burst_cnt3", 32'(fifo_count), 32'd3);
    wait_idle("burst", 4000);
    check_val("burst_done_n", 32'(dut_done_cnt - base), 32'd4);
    check_stream("burst");

    // Fill the FIFO with ticks stopped; the 18th push must be refused.
    base = dut_done_cnt;
    tick_mode = 0;
    for (int i = 0; i < 18; i++) drive(1'b1, 8'($urandom));
    drive(1'b0, 8'h00);
    @(negedge clk);
    check_val("full_count", 32'(fifo_count), 32'd16);
    check_val("full_ready", 32'(bus.tx_ready), 32'd0);
    check_val("full_busy", 32'(tx_busy), 32'd1);
    tick_div  = 2;
    tick_mode = 1;
    wait_idle("full", 8000);
    check_val("full_done_n", 32'(dut_done_cnt - base), 32'd17);
    check_val("full_n", 32'(rx_q.size()), 32'd17);
    check_stream("full");

    // Push coinciding with a pop at occupancy 1.
    base = dut_done_cnt;
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    @(negedge clk);
    check_val("simul_cnt_a", 32'(fifo_count), 32'd1);
    drive(1'b0, 8'h00);
    @(negedge clk);
    check_val("simul_cnt_b", 32'(fifo_count), 32'd1);
    check_val("simul_busy", 32'(tx_busy), 32'd1);
    wait_idle("simul", 2000);
    check_val("simul_done_n", 32'(dut_done_cnt - base), 32'd2);
    check_stream("simul");

    // Reset during data bit 3 of 0x0F with another byte still queued.
    drive(1'b1, 8'h0F);
    drive(1'b1, 8'h99);
    drive(1'b0, 8'h00);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        #1;
        if (m_active && m_ticks >= 16 * 4 + 4) begin
          hit = 1'b1;
          break;
        end
      end
      check_val("mid_reach", 32'(hit), 32'd1);
    end
    reset = 1'b1;
    #1;
    check_val("mid_pin", 32'(tx_pin), 32'd1);
    check_val("mid_count", 32'(fifo_count), 32'd0);
    check_val("mid_busy", 32'(tx_busy), 32'd0);
    check_val("mid_ready", 32'(bus.tx_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = dut_done_cnt;
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    wait_idle("post", 2000);
    check_val("post_done_n", 32'(dut_done_cnt - base), 32'd1);
    check_val("post_rx", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h3C);
    check_stream("post");

    // Random pushes against random tick spacing.
    tick_mode = 2;
    for (int i = 0; i < 150; i++) drive($urandom_range(0, 3) == 0, 8'($urandom));
    drive(1'b0, 8'h00);
    wait_idle("rand", 30000);
    check_stream("rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
